// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding,
// FSM state type and default latencies.
package md_pkg;

    // mdop encoding; 6 and 7 are reserved and behave as no-ops
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for several cycles
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the full HI/LO pair in
// one pass; md_ctrl only models the latency.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] abs_a, abs_b, b_safe, abs_b_safe;
    logic        [31:0] uq, ur, sq_mag, sr_mag;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes, then restores signs. The
    // 0x8000_0000 / -1 case falls out naturally: |a| = 0x8000_0000,
    // quotient negates back to 0x8000_0000, remainder is 0.
    assign abs_a      = a[31] ? (~a + 32'd1) : a;
    assign abs_b      = b[31] ? (~b + 32'd1) : b;
    // Divisors forced nonzero so the divider never sees /0; the zero case
    // is overridden below anyway.
    assign b_safe     = (b == 32'd0) ? 32'd1 : b;
    assign abs_b_safe = (b == 32'd0) ? 32'd1 : abs_b;
    assign uq         = a / b_safe;
    assign ur         = a % b_safe;
    assign sq_mag     = abs_a / abs_b_safe;
    assign sr_mag     = abs_a % abs_b_safe;

    // Select result per op, applying divide-by-zero rule
    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        case (op)
            MD_MULT:  {hi_n, lo_n} = sprod;
            MD_MULTU: {hi_n, lo_n} = uprod;
            MD_DIV: begin
                if (b == 32'd0) begin
                    lo_n = 32'hFFFF_FFFF;
                    hi_n = a;
                end else begin
                    lo_n = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
                    hi_n = a[31] ? (~sr_mag + 32'd1) : sr_mag;
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    lo_n = 32'hFFFF_FFFF;
                    hi_n = a;
                end else begin
                    lo_n = uq;
                    hi_n = ur;
                end
            end
            default: begin
                hi_n = 32'd0;
                lo_n = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, models multi-cycle latency with a
// down-counter, and requests ID stalls while a result is outstanding.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_E,
    input  logic [2:0]  mdop_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    input  logic        flush_E,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e      state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi_s, lo_s;
    logic [31:0]    hi_n, lo_n;
    logic           start_ok;

    md_arith u_arith (
        .op   (mdop_E),
        .a    (a_E),
        .b    (b_E),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    assign start_ok = start_E & ~flush_E;

    // A pending arith start stalls ID in the same cycle, before busy rises
    assign stall_md = md_D & (busy | (start_ok & md_is_arith(mdop_E)));

    // FSM, latency counter, shadow result and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_s  <= 32'd0;
            lo_s  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        case (mdop_E)
                            MD_MTHI: hi <= a_E;
                            MD_MTLO: lo <= a_E;
                            MD_MULT, MD_MULTU: begin
                                hi_s  <= hi_n;
                                lo_s  <= lo_n;
                                cnt   <= CW'(MULT_CYCLES - 1);
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                hi_s  <= hi_n;
                                lo_s  <= lo_n;
                                cnt   <= CW'(DIV_CYCLES - 1);
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // New starts here cannot happen legally and are dropped
                    if (cnt == '0) begin
                        hi    <= hi_s;
                        lo    <= lo_s;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
